// File: rtl/block_autocorrelator.sv
// block_autocorrelator
//   Streaming block autocorrelation. Each block of up to BLOCK_SIZE signed
//   samples produces LAGS+1 results, r[k] = sum x[n]*x[n-k] over the block.
//   The results are then streamed out one lag per word through a
//   valid/ready handshake.
//
//   Input side never stalls. Three stages per sample:
//     accept edge   -> products registered
//     next edge     -> accumulated
//     next edge     -> snapshot into the output bank
//   A finished block that finds the bank still busy is dropped, and
//   oOverrun is set.
//
// Ports
//   iClock, iReset_n           clock, async active-low reset
//   iValid, iSample, iLast     sample stream; iLast marks a short block's end
//   oACF, oLag, oLast, oValid  result word for lag oLag; oLast on lag LAGS
//   iReady                     consumer takes the word when high with oValid
//   oOverrun                   sticky: a completed block's results were dropped

// One lag lane: product register followed by accumulator.
module autocorr_lane #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 45
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic                       smp_vld,
  input  logic signed [SAMPLE_W-1:0] cur,
  input  logic signed [SAMPLE_W-1:0] tap,
  input  logic                       acc_en,
  input  logic                       acc_load,
  output logic signed [ACC_W-1:0]    acc
);
  localparam int PW = 2 * SAMPLE_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (smp_vld) prod <= PW'(cur) * PW'(tap);
      // First product of a block replaces whatever the previous block left.
      if (acc_en)  acc  <= acc_load ? prod_ext : acc + prod_ext;
    end
  end
endmodule

module block_autocorrelator #(
  parameter int SAMPLE_W   = 16,
  parameter int LAGS       = 12,
  parameter int BLOCK_SIZE = 4096,
  parameter int ACC_W      = 2*SAMPLE_W + $clog2(BLOCK_SIZE) + 1,
  localparam int LAG_W     = (LAGS > 0) ? $clog2(LAGS+1) : 1
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic                       iValid,
  input  logic signed [SAMPLE_W-1:0] iSample,
  input  logic                       iLast,
  output logic signed [ACC_W-1:0]    oACF,
  output logic [LAG_W-1:0]           oLag,
  output logic                       oValid,
  input  logic                       iReady,
  output logic                       oLast,
  output logic                       oOverrun
);
  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } stg_t;

  typedef enum logic {IDLE, STREAM} state_t;

  // ---------------- input side ----------------
  logic [CNT_W-1:0]                cnt;
  logic                            first_smp, blk_end;
  logic [LAGS-1:0][SAMPLE_W-1:0]   hist;   // hist[j] = x[n-1-j]
  logic [LAGS:0][SAMPLE_W-1:0]     tap;
  logic [LAGS:0][ACC_W-1:0]        acc;
  stg_t                            s1;     // product stage
  logic                            s2_end; // accumulators hold a finished block

  assign first_smp = (cnt == '0);
  assign blk_end   = iValid && (iLast || cnt == CNT_W'(BLOCK_SIZE-1));

  // The first sample of a block sees zero history, so no earlier block leaks in.
  for (genvar k = 0; k <= LAGS; k++) begin : g_tap
    if (k == 0) begin : g_cur
      assign tap[k] = iSample;
    end else begin : g_hist
      assign tap[k] = first_smp ? '0 : hist[k-1];
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt    <= '0;
      hist   <= '0;
      s1     <= '0;
      s2_end <= 1'b0;
    end else begin
      if (iValid) begin
        cnt     <= blk_end ? '0 : cnt + CNT_W'(1);
        hist[0] <= iSample;
        for (int j = 1; j < LAGS; j++) hist[j] <= first_smp ? '0 : hist[j-1];
      end
      s1.vld   <= iValid;
      s1.first <= iValid && first_smp;
      s1.last  <= blk_end;
      s2_end   <= s1.vld && s1.last;
    end
  end

  for (genvar k = 0; k <= LAGS; k++) begin : g_lane
    autocorr_lane #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_lane (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .smp_vld  (iValid),
      .cur      (iSample),
      .tap      (tap[k]),
      .acc_en   (s1.vld),
      .acc_load (s1.first),
      .acc      (acc[k])
    );
  end

  // ---------------- output side ----------------
  logic [LAGS:0][ACC_W-1:0] bank;
  state_t                   state, state_nxt;
  logic [LAG_W-1:0]         lag, lag_nxt;
  logic                     accept, bank_free, bank_ld, set_ovr;

  assign oValid = (state == STREAM);
  assign oLag   = lag;
  assign oLast  = oValid && (lag == LAG_W'(LAGS));
  assign oACF   = bank[lag];
  assign accept = oValid && iReady;
  // Bank can take a new block if idle, or if its final word leaves this edge.
  assign bank_free = (state == IDLE) || (accept && oLast);

  always_comb begin
    state_nxt = state;
    lag_nxt   = lag;
    bank_ld   = 1'b0;
    set_ovr   = 1'b0;
    unique case (state)
      IDLE:   ;
      STREAM: if (accept) begin
        if (oLast) begin
          state_nxt = IDLE;
          lag_nxt   = '0;
        end else begin
          lag_nxt = lag + LAG_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (s2_end) begin
      if (bank_free) begin
        bank_ld   = 1'b1;
        state_nxt = STREAM;
        lag_nxt   = '0;
      end else begin
        set_ovr = 1'b1;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state    <= IDLE;
      lag      <= '0;
      bank     <= '0;
      oOverrun <= 1'b0;
    end else begin
      state <= state_nxt;
      lag   <= lag_nxt;
      if (bank_ld) bank <= acc;
      if (set_ovr) oOverrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_block_autocorrelator.sv
module tb_block_autocorrelator;
  localparam int SW = 16;
  localparam int L1 = 3,  B1 = 8,    A1 = 2*SW + $clog2(B1) + 1;
  localparam int L2 = 12, B2 = 4096, A2 = 2*SW + $clog2(B2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  iValid, iLast, iReady;
  logic signed [SW-1:0]  iSample;
  logic signed [A1-1:0]  oACF;
  logic [1:0]            oLag;
  logic                  oValid, oLast, oOverrun;

  logic                  iValid2, iLast2, iReady2;
  logic signed [SW-1:0]  iSample2;
  logic signed [A2-1:0]  oACF2;
  logic [3:0]            oLag2;
  logic                  oValid2, oLast2, oOverrun2;

  block_autocorrelator #(.SAMPLE_W(SW), .LAGS(L1), .BLOCK_SIZE(B1)) dut (
    .iClock(clk), .iReset_n(rst_n), .iValid(iValid), .iSample(iSample), .iLast(iLast),
    .oACF(oACF), .oLag(oLag), .oValid(oValid), .iReady(iReady), .oLast(oLast),
    .oOverrun(oOverrun));

  block_autocorrelator dut_big (
    .iClock(clk), .iReset_n(rst_n), .iValid(iValid2), .iSample(iSample2), .iLast(iLast2),
    .oACF(oACF2), .oLag(oLag2), .oValid(oValid2), .iReady(iReady2), .oLast(oLast2),
    .oOverrun(oOverrun2));

  typedef struct { longint acf; int lag; bit last; } word_t;
  word_t exp_q[$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: direct sum of lagged products over the block.
  task automatic push_block(input int xs[$]);
    word_t w;
    for (int k = 0; k <= L1; k++) begin
      longint s = 0;
      for (int n = k; n < xs.size(); n++) s += longint'(xs[n]) * longint'(xs[n-k]);
      w.acf = s; w.lag = k; w.last = (k == L1);
      exp_q.push_back(w);
    end
  endtask

  task automatic send(input int x, input bit last);
    iValid = 1'b1; iSample = SW'(x); iLast = last;
    @(posedge clk); #1;
    iValid = 1'b0; iLast = 1'b0;
  endtask

  task automatic send_block(input int xs[$], input bit last_on_final);
    for (int i = 0; i < xs.size(); i++) send(xs[i], last_on_final && (i == xs.size()-1));
  endtask

  task automatic rand_block(input int n, output int xs[$]);
    xs = {};
    for (int i = 0; i < n; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || oValid) && n < 300) begin @(negedge clk); n++; end
    check({"drain_q_", tag}, exp_q.size(), 0);
    check({"drain_valid_", tag}, oValid, 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard on every accepted word of the small instance.
  always @(negedge clk) begin
    word_t w;
    if (rst_n && oValid && iReady) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_word: observed lag %0d acf %0d expected no word", oLag, oACF);
      end else begin
        w = exp_q.pop_front();
        check($sformatf("acf_lag%0d", w.lag), oACF, w.acf);
        check("lag", oLag, w.lag);
        check("last", oLast, w.last);
      end
    end
  end

  initial begin
    int xs[$], ys[$];
    rst_n = 1'b0; iValid = 0; iSample = 0; iLast = 0; iReady = 1;
    iValid2 = 0; iSample2 = 0; iLast2 = 0; iReady2 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", oValid, 0);
    check("rst_lag", oLag, 0);
    check("rst_acf", oACF, 0);
    check("rst_last", oLast, 0);
    check("rst_overrun", oOverrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Eight +1 samples ending on the block-size limit; latency check.
    xs = {1, 1, 1, 1, 1, 1, 1, 1};
    push_block(xs);
    send_block(xs, 0);
    check("lat_e0", oValid, 0);
    @(posedge clk); #1; check("lat_e1", oValid, 0);
    @(posedge clk); #1; check("lat_e2", oValid, 1);
    wait_drain("ones");

    // Short block: 13, -6, 0, 0.
    xs = {3, -2};
    push_block(xs);
    send_block(xs, 1);
    wait_drain("short");

    // Two 4-sample blocks back to back: stream must have no gap.
    rand_block(4, xs); rand_block(4, ys);
    push_block(xs); push_block(ys);
    send_block(xs, 1); send_block(ys, 1);
    for (int i = 0; i < 6; i++) begin @(negedge clk); check("contig_valid", oValid, 1); end
    wait_drain("contig");

    // Random back-to-back blocks, including iLast on the full-size sample.
    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(4, 8);
      rand_block(n, xs);
      push_block(xs);
      send_block(xs, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    wait_drain("random");
    check("random_overrun", oOverrun, 0);

    // Stall 5 cycles on lag 1 while the next block streams in.
    rand_block(8, xs); rand_block(8, ys);
    push_block(xs); push_block(ys);
    send_block(xs, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i == 4) repeat (2) begin @(posedge clk); #1; end
          send(ys[i], 0);
        end
      end
      begin
        logic signed [A1-1:0] h_acf;
        logic [1:0] h_lag;
        logic h_last;
        int n = 0;
        while (!(oValid && oLag == 2'd1) && n < 20) begin @(posedge clk); #1; n++; end
        check("stall_lag", oLag, 1);
        h_acf = oACF; h_lag = oLag; h_last = oLast;
        iReady = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_acf", oACF, h_acf);
          check("stall_lagh", oLag, h_lag);
          check("stall_lasth", oLast, h_last);
          check("stall_valid", oValid, 1);
          @(posedge clk); #1;
        end
        iReady = 1'b1;
      end
    join
    wait_drain("stall");
    check("stall_overrun", oOverrun, 0);

    // Second block finishes while the first is stalled: dropped, flag set.
    iReady = 1'b0;
    rand_block(3, xs); rand_block(2, ys);
    push_block(xs);
    send_block(xs, 1); send_block(ys, 1);
    repeat (6) begin @(posedge clk); #1; end
    check("ovr_flag", oOverrun, 1);
    check("ovr_valid", oValid, 1);
    check("ovr_lag", oLag, 0);
    check("ovr_acf", oACF, exp_q[0].acf);
    iReady = 1'b1;
    wait_drain("overrun");
    for (int i = 0; i < 3; i++) begin @(negedge clk); check("ovr_no_extra", oValid, 0); end
    check("ovr_sticky", oOverrun, 1);

    // Reset mid-stream with a partial block in flight.
    @(posedge clk); #1;
    rand_block(5, xs);
    push_block(xs);
    send_block(xs, 1);
    rand_block(3, ys);
    send_block(ys, 0);
    check("pre_rst_valid", oValid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", oValid, 0);
    check("mid_rst_lag", oLag, 0);
    check("mid_rst_last", oLast, 0);
    check("mid_rst_overrun", oOverrun, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rand_block(4, xs);
    push_block(xs);
    send_block(xs, 1);
    wait_drain("post_rst");

    // Default-size instance: full block of the most negative sample.
    for (int i = 0; i < B2; i++) begin
      iValid2 = 1'b1; iSample2 = -16'sd32768;
      @(posedge clk); #1;
    end
    iValid2 = 1'b0;
    begin
      int got = 0, n = 0;
      while (got <= L2 && n < 60) begin
        @(negedge clk); n++;
        if (oValid2) begin
          check($sformatf("big_acf%0d", got), oACF2, longint'(B2 - got) * (64'sd1 <<< 30));
          check("big_lag", oLag2, got);
          check("big_last", oLast2, (got == L2) ? 1 : 0);
          got++;
        end
      end
      check("big_words", got, L2 + 1);
      check("big_overrun", oOverrun2, 0);
    end

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_autocorrelator.md
BLOCK_AUTOCORRELATOR -- requirements
Module: block_autocorrelator

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning signed input sample width.
REQ-002 SHALL have parameter LAGS, default 12, meaning highest lag computed; lags 0..LAGS are produced.
REQ-003 SHALL have parameter BLOCK_SIZE, default 4096, meaning maximum samples per block.
REQ-004 SHALL have parameter ACC_W, default 2*SAMPLE_W+clog2(BLOCK_SIZE)+1, meaning accumulator and result width.
REQ-005 SHALL be built for one clock, with reset asynchronous and active-low.
REQ-006 iClock  in  1  sole clock; all state updates on its rising edge.
REQ-007 iReset_n  in  1  asynchronous active-low reset.
REQ-008 iValid  in  1  iSample valid this cycle; there is no input backpressure.
REQ-009 iSample  in  SAMPLE_W  signed two's-complement sample.
REQ-010 iLast  in  1  qualified by iValid; marks the final sample of a short block.
REQ-011 oACF  out  ACC_W  signed integer autocorrelation value for lag oLag.
REQ-012 oLag  out  clog2(LAGS+1)  lag index of oACF.
REQ-013 oValid  out  1  oACF/oLag/oLast valid.
REQ-014 iReady  in  1  consumer accepts the current result word when high together with oValid.
REQ-015 oLast  out  1  high with the lag-LAGS word.
REQ-016 oOverrun  out  1  sticky flag; a completed block's results were dropped.

Function
REQ-017 Sample accepted on any rising edge with iValid=1; block ends on the sample carrying iLast=1 or on the BLOCK_SIZE-th sample, whichever is first.
REQ-018 Per-block result for lag k: sum over n=k..N-1 of x[n]*x[n-k], N = samples in block; no sample from a previous block contributes.
REQ-019 History of LAGS previous samples reads as zero at block start; no idle bubble permitted between blocks (next block's first sample may arrive the cycle after the last).
REQ-020 Pipeline: acceptance edge registers LAGS+1 signed products; next edge accumulates (first sample of block loads product instead of adding); next edge snapshots to the output bank.
REQ-021 Latency: oValid rises on the 2nd rising edge after the edge accepting the block's last sample, if the output bank is free at that edge.
REQ-022 Arithmetic signed, products sign-extended to ACC_W; no saturation or wrap occurs for any in-range input.
REQ-023 Lags with k >= N SHALL report 0.
REQ-024 Output FSM states IDLE and STREAM; IDLE->STREAM on snapshot; in STREAM words emitted oLag=0..LAGS in order, advancing only on oValid&&iReady; STREAM->IDLE on acceptance of the oLast word.
REQ-025 While oValid=1 and iReady=0, oACF, oLag, oLast SHALL hold stable.
REQ-026 Snapshot arriving on the same edge as acceptance of the oLast word SHALL be taken; STREAM continues with oLag=0 of the new block, no gap.
REQ-027 Snapshot arriving while output bank busy otherwise: new results discarded, bank untouched, oOverrun set and held until reset.
REQ-028 Accumulation continues unaffected by output backpressure; input side never stalls.
REQ-029 iLast on a sample that is also the BLOCK_SIZE-th ends a single block (no empty block).

Reset
REQ-030 iReset_n=0 SHALL asynchronously clear history, products, accumulators, sample count, output bank, FSM to IDLE, oValid=0, oLag=0, oACF=0, oLast=0, oOverrun=0.
REQ-031 Reset mid-block or mid-stream SHALL discard all partial and pending results; the first sample after release starts a new block.

Verification
REQ-032 SAMPLE_W=16, LAGS=3, BLOCK_SIZE=8, eight samples of +1, iReady=1 -> oACF 8,7,6,5 with oLag 0..3, oLast on lag 3, oValid rising 2 edges after the last accept.
REQ-033 Short block: samples 3, -2 with iLast on -2 (LAGS=3) -> oACF 13,-6,0,0.
REQ-034 Default params, 4096 samples of -32768 -> lag0 = 2^42, lag12 = 4084*2^30, no overflow.
REQ-035 Back-to-back blocks with iReady held low 5 cycles during lag 1 -> word stable throughout, second block's results correct and contiguous, oOverrun=0 when drained in time.
REQ-036 Two short blocks completing while first result still stalled (iReady=0) -> oOverrun=1, first block's words delivered intact, second dropped.
REQ-037 iReset_n pulsed low mid-STREAM -> oValid=0 immediately, next block after release yields correct values.
